// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, mode constants and prescaler width helper for prog_timer
package timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD = 1'b1;
  function automatic int div_w(input int f_clk, input int f_tick);
    return (f_clk / f_tick) < 2 ? 1 : $clog2(f_clk / f_tick);
  endfunction
endpackage

// File: rtl/prog_timer_tick_gen.sv
// tick_gen: clearable, enable-gated prescaler emitting a one-cycle tick every F_CLK/F_TICK running cycles
module tick_gen
  import timer_pkg::*;
#(
  parameter int F_CLK = 50_000_000,
  parameter int F_TICK = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);
  localparam int DIV = F_CLK / F_TICK;
  localparam int DIV_W = div_w(F_CLK, F_TICK);
  if (F_TICK <= 0 || DIV < 2 || (F_CLK % F_TICK) != 0) begin : g_bad_div
    $error("tick_gen: F_CLK/F_TICK must be an integer >= 2");
  end
  logic [DIV_W-1:0] cnt_q, cnt_d;
  assign o_tick = i_en && (cnt_q == DIV_W'(DIV - 1));
  // advance while enabled, wrap after the tick, hold otherwise
  always_comb begin
    cnt_d = i_clr ? '0 : !i_en ? cnt_q : o_tick ? '0 : cnt_q + 1'b1;
  end
  // prescaler register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/prog_timer.sv
// prog_timer: one-shot / auto-reload countdown timer with pause, abort and expiry pulse; sticky irq when PROG_TIMER_STICKY_EN is defined
module prog_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int F_CLK = 50_000_000,
  parameter int F_TICK = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_mode,
  input  logic             i_start,
  input  logic             i_pause,
  input  logic             i_abort,
`ifdef PROG_TIMER_STICKY_EN
  input  logic             i_irq_clr,
  output logic             o_irq,
`endif
  output logic [WIDTH-1:0] o_count,
  output logic             o_expired,
  output logic             o_busy
);
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("prog_timer: WIDTH must be in 2..32");
  end
  state_e state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic mode_q, mode_d, expired_q, expired_d, tick;
  tick_gen #(.F_CLK(F_CLK), .F_TICK(F_TICK)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .i_clr (i_abort | i_start),
    .i_en  ((state_q == RUN) & ~i_pause),
    .o_tick(tick)
  );
  // control priority: abort > start > tick; pause is folded into the tick enable
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mode_d = mode_q;
    expired_d = 1'b0;
    if (i_abort) begin
      state_d = IDLE;
      count_d = '0;
    end else if (i_start) begin
      count_d = i_load_val;
      mode_d = i_mode;
      state_d = (i_load_val == '0) ? DONE : RUN;
      expired_d = (i_load_val == '0);
    end else if (state_q == RUN && tick) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else if (count_q == WIDTH'(1)) begin
        count_d = '0;
        expired_d = 1'b1;
        state_d = (mode_q == MODE_RELOAD) ? RUN : DONE;
      end else begin
        count_d = i_load_val;
        expired_d = (i_load_val == '0);
        state_d = (i_load_val == '0) ? DONE : RUN;
      end
    end
  end
  // state, count, latched mode and expiry pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      mode_q <= MODE_ONESHOT;
      expired_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mode_q <= mode_d;
      expired_q <= expired_d;
    end
  end
  assign o_count = count_q;
  assign o_expired = expired_q;
  assign o_busy = (state_q == RUN);
`ifdef PROG_TIMER_STICKY_EN
  logic irq_q;
  // sticky interrupt: an expiry pulse sets it and beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else irq_q <= expired_q | (irq_q & ~i_irq_clr);
  end
  assign o_irq = irq_q;
`endif
endmodule

// File: tb/tb_prog_timer.sv
// tb_prog_timer: directed and randomized checks of prog_timer against an elapsed-time arithmetic model
module tb_prog_timer;
  localparam int DIV = 10;
  logic clk = 1'b0;
  logic rst = 1'b1, st = 1'b0, ab = 1'b0, pz = 1'b0, md = 1'b0, irq_clr = 1'b0;
  logic [7:0] ld = '0;
  logic [7:0] o_count;
  logic o_expired, o_busy, o_irq;
  int checks = 0, failures = 0;
  int m_state = 0, m_load = 0, m_mode = 0, m_act = 0;
  bit m_exp = 0, m_irq = 0;
  always #5 clk = ~clk;
  prog_timer #(.WIDTH(8), .F_CLK(10), .F_TICK(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_load_val(ld),
    .i_mode    (md),
    .i_start   (st),
    .i_pause   (pz),
    .i_abort   (ab),
`ifdef PROG_TIMER_STICKY_EN
    .i_irq_clr (irq_clr),
    .o_irq     (o_irq),
`endif
    .o_count   (o_count),
    .o_expired (o_expired),
    .o_busy    (o_busy)
  );
`ifndef PROG_TIMER_STICKY_EN
  assign o_irq = 1'b0;
`endif
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask
  // model: state 0=idle 1=run 2=done; count derived from active cycles since start
  task automatic model_edge();
    int n;
    m_irq = rst ? 1'b0 : (m_exp ? 1'b1 : (irq_clr ? 1'b0 : m_irq));
    m_exp = 0;
    if (rst) begin
      m_state = 0; m_mode = 0; m_act = 0;
    end else if (ab) begin
      m_state = 0;
    end else if (st) begin
      m_load = int'(ld); m_mode = int'(md); m_act = 0;
      m_state = (ld == 0) ? 2 : 1;
      m_exp = (ld == 0);
    end else if (m_state == 1 && !pz) begin
      m_act++;
      if (m_act % DIV == 0) begin
        n = m_act / DIV;
        if (m_mode == 0 && n == m_load) begin
          m_exp = 1; m_state = 2;
        end else if (m_mode == 1 && n >= m_load && (n - m_load) % (m_load + 1) == 0) begin
          m_exp = 1;
        end
      end
    end
  endtask
  function automatic int m_count();
    int n = m_act / DIV;
    if (m_state != 1) return 0;
    return (m_mode == 0) ? m_load - n : m_load - (n % (m_load + 1));
  endfunction
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("count", 32'(o_count), 32'(m_count()));
    chk("expired", 32'(o_expired), 32'(m_exp));
    chk("busy", 32'(o_busy), 32'(m_state == 1));
`ifdef PROG_TIMER_STICKY_EN
    chk("irq", 32'(o_irq), 32'(m_irq));
`endif
  endtask
  task automatic start(input int load, input bit mode);
    ld = 8'(load); md = mode; st = 1'b1;
    step();
    st = 1'b0;
  endtask
  initial begin
    repeat (2) step();
    chk("reset_count", 32'(o_count), 0);
    chk("reset_busy", 32'(o_busy), 0);
    rst = 1'b0;
    start(3, 0);
    repeat (35) step();
    start(2, 1);
    repeat (65) step();
    start(5, 0);
    repeat (11) step();
    pz = 1'b1;
    repeat (25) step();
    pz = 1'b0;
    repeat (60) step();
    start(4, 0);
    repeat (14) step();
    ab = 1'b1; st = 1'b1;
    step();
    chk("abort_wins", 32'(o_busy), 0);
    ab = 1'b0;
    step();
    st = 1'b0;
    repeat (50) step();
    start(0, 1);
    chk("zero_load_exp", 32'(o_expired), 1);
    repeat (3) step();
    start(4, 1);
    repeat (17) step();
    rst = 1'b1;
    step();
    chk("rst_mid_count", 32'(o_count), 0);
    rst = 1'b0;
    repeat (3) step();
    start(1, 0);
    repeat (9) step();
    irq_clr = 1'b1;
    step();
    step();
    irq_clr = 1'b0;
    repeat (3) step();
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        ld = 8'($urandom_range(0, 5)); md = 1'($urandom); st = 1'b1;
      end else st = 1'b0;
      ab = ($urandom_range(0, 199) == 0);
      rst = ($urandom_range(0, 999) == 0);
      irq_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 29) == 0) pz = ~pz;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
